mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch port (IF stage, read-only) and the data port (MEM stage loads, stores, LL and SC).
- Serialises accesses with a registered request/ack handshake and holds each finished read word for the pipeline.
- Raises per-port stall requests to ctrl until that port's access completes.
- Gives data priority over fetch, drains in-flight transfers on flush, and times out hung transfers.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a transfer waits for bus_ack_i before it is aborted with an error (valid range 1..255).
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset (`RstEnable` = 1'b1)
- flush  in  1  pipeline flush from ctrl
- rom_ce_i  in  1  fetch request
- rom_addr_i  in  32  fetch address
- rom_data_o  out  32  fetched instruction (latched)
- inst_stallreq_o  out  1  stall request for the IF stage
- mem_ce_i  in  1  data request
- mem_we_i  in  1  data write enable
- mem_sel_i  in  4  byte lanes ([3] = bits 31:24)
- mem_addr_i  in  32  data address
- mem_data_i  in  32  store data
- mem_data_o  out  32  load data (latched)
- data_stallreq_o  out  1  stall request for the MEM stage
- bus_req_o  out  1  bus transfer valid
- bus_we_o  out  1  bus write
- bus_sel_o  out  4  bus byte lanes
- bus_addr_o  out  32  bus address
- bus_wdata_o  out  32  bus write data
- bus_rdata_i  in  32  bus read data, valid with ack
- bus_ack_i  in  1  transfer complete
- bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- States: IDLE, DBUS, IBUS, DDONE, IDONE, DRAIN. All bus_* outputs, rom_data_o, mem_data_o, bus_err_o, state and counter are registered.
- Reset (rst high at posedge) sets:
  - state to IDLE;
  - all bus_* outputs, bus_err_o, rom_data_o, mem_data_o and the counter to 0.
  - The stall outputs are combinationally 0 while rst is high.
- Reset mid-transfer: bus_req_o drops on the reset edge and no result is delivered.
- IDLE with flush = 0:
  - mem_ce_i = 1: go to DBUS; latch the mem_* request onto the bus_* outputs; bus_req_o = 1; counter = 0.
  - Otherwise rom_ce_i = 1: go to IBUS; bus_addr_o = rom_addr_i, bus_we_o = 0, bus_sel_o = 4'b1111, bus_req_o = 1.
  - Data wins whenever both ports request in the same cycle.
- IDLE with flush = 1: no grant is made.
- DBUS / IBUS:
  - bus_* outputs stay stable while bus_req_o = 1.
  - The counter increments each cycle that bus_ack_i = 0.
  - On bus_ack_i = 1: bus_req_o = 0; for a read, latch bus_rdata_i into mem_data_o (DBUS) or rom_data_o (IBUS). For a write, mem_data_o is left unchanged. Next state is DDONE or IDONE, or DRAIN-exit to IDLE if flush was seen during the transfer.
  - A bus_ack_i in the same cycle bus_req_o first rises is legal.
- Timeout: when the counter reaches TIMEOUT_CYCLES - 1 with no ack:
  - bus_req_o = 0 and the read result is latched as 32'h0;
  - bus_err_o pulses for 1 cycle;
  - the state proceeds as if acked.
- Flush during DBUS/IBUS: the transfer is not aborted (stores must complete). A sticky flag moves the state to DRAIN semantics: on ack, go to IDLE with no DONE cycle and no latch of the result.
- DDONE / IDONE: last exactly 1 cycle, then go to IDLE. The next grant is decided in that IDLE cycle.
- Stall outputs (combinational):
  - data_stallreq_o = mem_ce_i AND state != DDONE.
  - inst_stallreq_o = rom_ce_i AND state != IDONE.
  - During DRAIN/flush, each stall follows its ce input (new requests wait).
- Minimum latency: request seen at cycle N, bus_req_o high at N+1, ack at N+1, DONE at N+2, stall released in cycle N+2. The requester holds its inputs stable while its stall is high.
- Back-to-back: if the data port keeps requesting after DDONE, the fetch port waits (fixed priority; MEM stalls are bounded by the pipeline).

Test Plan:
- Lone load: mem_ce_i = 1, we = 0, addr 0x100, ack in the first cycle with rdata 0xDEADBEEF -> bus_req_o high 1 cycle; data_stallreq_o high 2 cycles then low in DDONE; mem_data_o = 0xDEADBEEF.
- Simultaneous requests: rom_ce_i = 1 and mem_ce_i = 1 (store 0x12345678, sel 4'b1111) -> the data transfer goes first; fetch bus_req_o rises 1 cycle after DDONE; inst_stallreq_o stays high until IDONE.
- Wait states: ack delayed 3 cycles -> bus_addr_o, bus_sel_o and bus_wdata_o are stable throughout; stall is released exactly 1 cycle after ack.
- Flush during fetch: flush pulses while in IBUS, then ack -> rom_data_o unchanged; no IDONE cycle; the next request is granted from IDLE.
- Timeout: TIMEOUT_CYCLES = 4, no ack -> bus_req_o drops after 4 cycles; bus_err_o pulses once; mem_data_o = 0; stall released in DDONE.
- Reset mid-transfer: rst = 1 while in DBUS -> next cycle state is IDLE, bus_req_o = 0, both stall outputs 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and the data port.
// Data has fixed priority; flushed transfers complete but their result is discarded.
module mem_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        rom_ce_i,
   input  logic [31:0] rom_addr_i,
   output logic [31:0] rom_data_o,
   output logic        inst_stallreq_o,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        data_stallreq_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        bus_err_o
);

   // Handshake: bus_req_o is held with stable bus_* fields until the cycle
   // bus_ack_i is sampled high (or the timeout fires); ack may arrive in the
   // very first request cycle.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DBUS  = 3'd1,
      S_IBUS  = 3'd2,
      S_DDONE = 3'd3,
      S_IDONE = 3'd4,
      S_DRAIN = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_req;
   logic              r_we;
   logic [3:0]        r_sel;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rom_data;
   logic [31:0]       r_mem_data;
   logic              r_err;
   logic              w_busy;
   logic              w_timeout;
   logic              w_done;
   logic              w_drop;
   logic              w_grant_d;
   logic              w_grant_i;

   assign w_busy    = (r_state == S_DBUS) || (r_state == S_IBUS) || (r_state == S_DRAIN);
   assign w_timeout = w_busy && !bus_ack_i && (r_cnt == TO_LAST);
   assign w_done    = w_busy && (bus_ack_i || w_timeout);
   // A flush seen at any point of the transfer, including the ack cycle, discards it.
   assign w_drop    = (r_state == S_DRAIN) || flush;
   assign w_grant_d = (r_state == S_IDLE) && !flush && mem_ce_i;
   assign w_grant_i = (r_state == S_IDLE) && !flush && !mem_ce_i && rom_ce_i;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_d)      w_next_state = S_DBUS;
            else if (w_grant_i) w_next_state = S_IBUS;
         end
         S_DBUS: begin
            if (w_done)     w_next_state = w_drop ? S_IDLE : S_DDONE;
            else if (flush) w_next_state = S_DRAIN;
         end
         S_IBUS: begin
            if (w_done)     w_next_state = w_drop ? S_IDLE : S_IDONE;
            else if (flush) w_next_state = S_DRAIN;
         end
         S_DRAIN: if (w_done) w_next_state = S_IDLE;
         S_DDONE: w_next_state = S_IDLE;
         S_IDONE: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_sel      <= 4'b0;
         r_addr     <= 32'b0;
         r_wdata    <= 32'b0;
         r_rom_data <= 32'b0;
         r_mem_data <= 32'b0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_err <= w_timeout;
         if (w_grant_d) begin
            r_req   <= 1'b1;
            r_we    <= mem_we_i;
            r_sel   <= mem_sel_i;
            r_addr  <= mem_addr_i;
            r_wdata <= mem_data_i;
            r_cnt   <= '0;
         end else if (w_grant_i) begin
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_sel   <= 4'b1111;
            r_addr  <= rom_addr_i;
            r_cnt   <= '0;
         end else if (w_busy) begin
            if (w_done) r_req <= 1'b0;
            else        r_cnt <= r_cnt + 1'b1;
         end
         // A timed-out read delivers zero so the pipeline never sees stale data.
         if (w_done && !w_drop && !r_we) begin
            if (r_state == S_DBUS) r_mem_data <= w_timeout ? 32'h0 : bus_rdata_i;
            if (r_state == S_IBUS) r_rom_data <= w_timeout ? 32'h0 : bus_rdata_i;
         end
      end
   end

   always_comb begin
      data_stallreq_o = !rst && mem_ce_i && (r_state != S_DDONE);
      inst_stallreq_o = !rst && rom_ce_i && (r_state != S_IDONE);
   end

   assign bus_req_o   = r_req;
   assign bus_we_o    = r_we;
   assign bus_sel_o   = r_sel;
   assign bus_addr_o  = r_addr;
   assign bus_wdata_o = r_wdata;
   assign bus_err_o   = r_err;
   assign rom_data_o  = r_rom_data;
   assign mem_data_o  = r_mem_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of data transfers plus hand-written corner
// sequences (priority, flush drain, timeout, reset mid-transfer).
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;
   logic        inst_stallreq_o;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        data_stallreq_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        bus_err_o;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
      .inst_stallreq_o(inst_stallreq_o),
      .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
      .data_stallreq_o(data_stallreq_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
      .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] m_mem = 32'h0;
   logic [31:0] m_rom = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_pop(input string name, input logic [31:0] act);
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: scoreboard empty, got %h", name, act);
      end else begin
         chk(name, act, exp_q.pop_front());
      end
   endtask

   // drivers
   task automatic idle_inputs();
      flush = 0; rom_ce_i = 0; rom_addr_i = 0;
      mem_ce_i = 0; mem_we_i = 0; mem_sel_i = 0; mem_addr_i = 0; mem_data_i = 0;
      bus_rdata_i = 0; bus_ack_i = 0;
   endtask

   // One data transfer from IDLE; ack after 'delay' wait cycles.
   task automatic data_xfer(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
      int n;
      @(negedge clk);
      mem_ce_i = 1; mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr; mem_data_i = wdata;
      if (!we) m_mem = rdata;
      exp_q.push_back(m_mem);
      #1 chk("dstall_idle", 32'(data_stallreq_o), 32'd1);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus_req_o && n < 20);
      chk("grant_latency", 32'(n), 32'd1);
      chk("bus_addr", bus_addr_o, addr);
      chk("bus_sel", 32'(bus_sel_o), 32'(sel));
      chk("bus_we", 32'(bus_we_o), 32'(we));
      if (we) chk("bus_wdata", bus_wdata_o, wdata);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("wait_req", 32'(bus_req_o), 32'd1);
         chk("wait_addr", bus_addr_o, addr);
         chk("wait_sel", 32'(bus_sel_o), 32'(sel));
         if (we) chk("wait_wdata", bus_wdata_o, wdata);
         chk("wait_dstall", 32'(data_stallreq_o), 32'd1);
      end
      bus_ack_i = 1; bus_rdata_i = rdata;
      #1 chk("ack_dstall", 32'(data_stallreq_o), 32'd1);
      @(negedge clk);
      bus_ack_i = 0; bus_rdata_i = 32'h0BAD0BAD;
      chk("ddone_req", 32'(bus_req_o), 32'd0);
      chk("ddone_dstall", 32'(data_stallreq_o), 32'd0);
      chk_pop("mem_data", mem_data_o);
      mem_ce_i = 0;
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n;
      idle_inputs();

      // reset: stalls must be gated even with requests pending
      rst = 1; mem_ce_i = 1; rom_ce_i = 1;
      repeat (2) @(negedge clk);
      chk("rst_dstall", 32'(data_stallreq_o), 32'd0);
      chk("rst_istall", 32'(inst_stallreq_o), 32'd0);
      chk("rst_req", 32'(bus_req_o), 32'd0);
      chk("rst_addr", bus_addr_o, 32'd0);
      chk("rst_mem_data", mem_data_o, 32'd0);
      chk("rst_rom_data", rom_data_o, 32'd0);
      chk("rst_err", 32'(bus_err_o), 32'd0);
      mem_ce_i = 0; rom_ce_i = 0;
      rst = 0;
      @(negedge clk);

      // table of data transfers: loads, stores, wait states up to the timeout edge
      vecs[0] = '{1'b0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF, 0};
      vecs[1] = '{1'b1, 4'b1111, 32'h104, 32'h12345678, 32'h0,        0};
      vecs[2] = '{1'b0, 4'b0011, 32'h108, 32'h0,        32'hCAFEF00D, 3};
      vecs[3] = '{1'b1, 4'b1000, 32'h10C, 32'hA5A5A5A5, 32'h77777777, 3};
      vecs[4] = '{1'b0, 4'b0100, 32'h110, 32'h0,        32'h0000_0001, 1};
      vecs[5] = '{1'b1, 4'b0001, 32'h114, 32'hFFFF0000, 32'h0,        2};
      vecs[6] = '{1'b0, 4'b1111, 32'h118, 32'h0,        $urandom,     $urandom_range(0, 3)};
      vecs[7] = '{1'b0, 4'b1111, 32'h11C, 32'h0,        32'h5555AAAA, 0};
      for (int i = 0; i < 8; i++)
         data_xfer(vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].delay);

      // simultaneous requests: data store first, then fetch
      @(negedge clk);
      mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b1111; mem_addr_i = 32'h200; mem_data_i = 32'h12345678;
      rom_ce_i = 1; rom_addr_i = 32'h0040_0000;
      @(negedge clk);
      chk("prio_req", 32'(bus_req_o), 32'd1);
      chk("prio_we", 32'(bus_we_o), 32'd1);
      chk("prio_addr", bus_addr_o, 32'h200);
      chk("prio_wdata", bus_wdata_o, 32'h12345678);
      bus_ack_i = 1;
      @(negedge clk);
      bus_ack_i = 0;
      chk("prio_ddone_dstall", 32'(data_stallreq_o), 32'd0);
      chk("prio_ddone_istall", 32'(inst_stallreq_o), 32'd1);
      chk("prio_store_keeps", mem_data_o, m_mem);
      mem_ce_i = 0;
      @(negedge clk);
      chk("prio_idle_req", 32'(bus_req_o), 32'd0);
      chk("prio_idle_istall", 32'(inst_stallreq_o), 32'd1);
      @(negedge clk);
      chk("fetch_req", 32'(bus_req_o), 32'd1);
      chk("fetch_addr", bus_addr_o, 32'h0040_0000);
      chk("fetch_sel", 32'(bus_sel_o), 32'hF);
      chk("fetch_we", 32'(bus_we_o), 32'd0);
      m_rom = 32'h3C010001;
      exp_q.push_back(m_rom);
      bus_ack_i = 1; bus_rdata_i = m_rom;
      @(negedge clk);
      bus_ack_i = 0;
      chk("idone_istall", 32'(inst_stallreq_o), 32'd0);
      chk_pop("rom_data", rom_data_o);
      rom_ce_i = 0;

      // flush during fetch: result dropped, no IDONE, re-grant from IDLE
      @(negedge clk);
      rom_ce_i = 1; rom_addr_i = 32'h0040_0004;
      @(negedge clk);
      chk("fl_req", 32'(bus_req_o), 32'd1);
      flush = 1;
      @(negedge clk);
      flush = 0;
      chk("fl_drain_req", 32'(bus_req_o), 32'd1);
      bus_ack_i = 1; bus_rdata_i = 32'hBADBAD00;
      @(negedge clk);
      bus_ack_i = 0;
      chk("fl_after_req", 32'(bus_req_o), 32'd0);
      chk("fl_no_idone", 32'(inst_stallreq_o), 32'd1);
      chk("fl_rom_kept", rom_data_o, m_rom);
      @(negedge clk);
      chk("fl_regrant", 32'(bus_req_o), 32'd1);
      m_rom = 32'h24020005;
      exp_q.push_back(m_rom);
      bus_ack_i = 1; bus_rdata_i = m_rom;
      @(negedge clk);
      bus_ack_i = 0;
      chk("fl_idone_istall", 32'(inst_stallreq_o), 32'd0);
      chk_pop("fl_rom_data", rom_data_o);
      rom_ce_i = 0;

      // timeout: no ack, 4 request cycles, error pulse, zero delivered
      @(negedge clk);
      mem_ce_i = 1; mem_we_i = 0; mem_sel_i = 4'b1111; mem_addr_i = 32'h300;
      m_mem = 32'h0;
      exp_q.push_back(m_mem);
      @(negedge clk);
      n = 0;
      while (bus_req_o && n < 20) begin n++; @(negedge clk); end
      chk("to_req_cycles", 32'(n), 32'd4);
      chk("to_err", 32'(bus_err_o), 32'd1);
      chk("to_dstall", 32'(data_stallreq_o), 32'd0);
      chk_pop("to_mem_data", mem_data_o);
      mem_ce_i = 0;
      @(negedge clk);
      chk("to_err_pulse", 32'(bus_err_o), 32'd0);

      // reset mid-transfer
      @(negedge clk);
      mem_ce_i = 1; mem_addr_i = 32'h400; rom_ce_i = 1;
      @(negedge clk);
      chk("rm_req", 32'(bus_req_o), 32'd1);
      rst = 1;
      #1 chk("rm_dstall", 32'(data_stallreq_o), 32'd0);
      chk("rm_istall", 32'(inst_stallreq_o), 32'd0);
      bus_ack_i = 1; bus_rdata_i = 32'hFEEDFACE;
      @(negedge clk);
      bus_ack_i = 0;
      chk("rm_req_drop", 32'(bus_req_o), 32'd0);
      chk("rm_no_result", mem_data_o, 32'd0);
      mem_ce_i = 0; rom_ce_i = 0; rst = 0;
      @(negedge clk);
      chk("rm_idle_req", 32'(bus_req_o), 32'd0);

      // report
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL leftover: %0d expected results never produced", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
